// File: rtl/afu_null_port_pkg.sv
// Shared types and constants for the null-AFU port array.
// Header layouts, register offsets and lane FSM states.
package afu_null_port_pkg;

  localparam int PFVF_W = 15;

  localparam logic [15:0] DFH_OFF     = 16'h0000;
  localparam logic [15:0] SCRATCH_OFF = 16'h0008;
  localparam logic [15:0] RDCNT_OFF   = 16'h0010;

  localparam logic [3:0]  DFH_TYPE = 4'h3;
  localparam logic        DFH_EOL  = 1'b1;
  localparam logic [23:0] DFH_NEXT = 24'h0;
  localparam logic [3:0]  DFH_REV  = 4'h0;

  localparam logic [7:0] FMT_MRD32 = 8'h00;
  localparam logic [7:0] FMT_MRD64 = 8'h20;
  localparam logic [7:0] FMT_MWR32 = 8'h40;
  localparam logic [7:0] FMT_MWR64 = 8'h60;
  localparam logic [7:0] FMT_CPLD  = 8'h4A;
  localparam logic [2:0] CPL_SC    = 3'b000;

  typedef enum logic [1:0] {IDLE, DRAIN, CPL} fsm_t;

  typedef logic [PFVF_W-1:0] pf_vf_info_t;

  typedef struct packed {
    logic [127:0] rsvd2;
    logic [63:0]  addr;
    logic [15:0]  req_id;
    logic [7:0]   tag;
    logic [15:0]  rsvd1;
    logic [9:0]   length;
    logic [5:0]   rsvd0;
    logic [7:0]   fmt_type;
  } req_hdr_t;

  typedef struct packed {
    logic [127:0] rsvd3;
    pf_vf_info_t  pf_vf;
    logic [48:0]  rsvd2;
    logic [15:0]  req_id;
    logic [7:0]   tag;
    logic         rsvd1;
    logic [6:0]   lower_addr;
    logic [11:0]  byte_count;
    logic [2:0]   status;
    logic [8:0]   rsvd0;
    logic [7:0]   fmt_type;
  } cpl_hdr_t;

  function automatic logic [63:0] dfh_word(input logic [11:0] fid);
    return {DFH_TYPE, 19'h0, DFH_EOL, DFH_NEXT, DFH_REV, fid};
  endfunction

endpackage

// File: rtl/afu_null_port_lane.sv
// One null-AFU lane: MMIO responder with DFH, scratch and read counter.
// Drains RX B and keeps TX B idle.
module afu_null_port_lane
  import afu_null_port_pkg::*;
#(
  parameter int          DATA_W  = 512,
  parameter logic [11:0] FEAT_ID = 12'h0,
  parameter pf_vf_info_t PF_VF   = '0,
  parameter int          CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              port_rst,
  input  logic              rx_a_tvalid,
  output logic              rx_a_tready,
  input  logic              rx_a_tlast,
  input  logic [DATA_W-1:0] rx_a_tdata,
  output logic              tx_a_tvalid,
  input  logic              tx_a_tready,
  output logic              tx_a_tlast,
  output logic [DATA_W-1:0] tx_a_tdata,
  input  logic              rx_b_tvalid,
  output logic              rx_b_tready,
  output logic              tx_b_tvalid
);

  logic              lane_rst;
  fsm_t              state;
  logic [63:0]       scratch;
  logic [CNT_W-1:0]  rd_cnt;
  logic [7:0]        tag_q;
  logic [15:0]       req_id_q;
  logic [15:0]       addr_q;
  logic              len2_q;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic [DATA_W-1:0] tx_next;
  logic [63:0]       reg_val;
  logic [63:0]       rd_data;
  logic [15:0]       reg_off;
  cpl_hdr_t          cpl;
  req_hdr_t          hdr;
  logic [63:0]       payload;
  logic              accept;
  logic              is_mrd;
  logic              is_mwr;
  logic              len_ok;
  logic              unused_bits;

  assign lane_rst    = rst | port_rst;
  assign hdr         = rx_a_tdata[255:0];
  assign payload     = rx_a_tdata[256 +: 64];
  assign accept      = rx_a_tvalid & rx_a_tready;
  assign is_mrd      = (hdr.fmt_type == FMT_MRD32) |
                       (hdr.fmt_type == FMT_MRD64);
  assign is_mwr      = (hdr.fmt_type == FMT_MWR32) |
                       (hdr.fmt_type == FMT_MWR64);
  assign len_ok      = (hdr.length == 10'd1) |
                       (hdr.length == 10'd2);
  assign rx_a_tready = ~lane_rst & (state != CPL);
  assign rx_b_tready = 1'b1;
  assign tx_b_tvalid = 1'b0;
  assign tx_a_tvalid = tx_valid;
  assign tx_a_tlast  = tx_valid;
  assign tx_a_tdata  = tx_data;
  assign unused_bits = ^{rx_b_tvalid, rx_a_tdata};
  assign reg_off     = {addr_q[15:3], 3'b000};

  always_comb begin
    reg_val = '0;
    unique case (1'b1)
      (reg_off == DFH_OFF):     reg_val = dfh_word(FEAT_ID);
      (reg_off == SCRATCH_OFF): reg_val = scratch;
      (reg_off == RDCNT_OFF):   reg_val = 64'(rd_cnt);
      default:                  reg_val = '0;
    endcase
  end

  // Single-DW reads pick the half selected by addr[2].
  assign rd_data = len2_q   ? reg_val :
                   addr_q[2] ? {32'h0, reg_val[63:32]} :
                               {32'h0, reg_val[31:0]};

  always_comb begin
    cpl            = '0;
    cpl.fmt_type   = FMT_CPLD;
    cpl.status     = CPL_SC;
    cpl.byte_count = len2_q ? 12'd8 : 12'd4;
    cpl.lower_addr = addr_q[6:0];
    cpl.tag        = tag_q;
    cpl.req_id     = req_id_q;
    cpl.pf_vf      = PF_VF;
    tx_next        = '0;
    tx_next[255:0] = cpl;
    tx_next[256 +: 64] = rd_data;
  end

  always_ff @(posedge clk or posedge lane_rst) begin
    if (lane_rst) begin
      state    <= IDLE;
      scratch  <= '0;
      rd_cnt   <= '0;
      tag_q    <= '0;
      req_id_q <= '0;
      addr_q   <= '0;
      len2_q   <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          if (!rx_a_tlast) begin
            state <= DRAIN;
          end else if (is_mrd && len_ok) begin
            tag_q    <= hdr.tag;
            req_id_q <= hdr.req_id;
            addr_q   <= hdr.addr[15:0];
            len2_q   <= (hdr.length == 10'd2);
            state    <= CPL;
          end else if (is_mwr && hdr.addr[15:0] == SCRATCH_OFF) begin
            if (hdr.length == 10'd2)
              scratch <= payload;
            else if (hdr.length == 10'd1)
              scratch[31:0] <= payload[31:0];
          end
        end
        DRAIN: if (accept && rx_a_tlast) state <= IDLE;
        CPL: begin
          // First CPL cycle builds the beat; rd_cnt moves on handshake.
          if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= tx_next;
          end else if (tx_a_tready) begin
            tx_valid <= 1'b0;
            rd_cnt   <= rd_cnt + 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/afu_null_port_array.sv
// Array of independent null-AFU lanes for unclaimed PF/VF ports.
// Pure per-lane slicing around afu_null_port_lane.
module afu_null_port_array
  import afu_null_port_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 512,
  parameter logic [NUM_PORTS*12-1:0] PORT_FEAT_ID = '0,
  parameter logic [NUM_PORTS*PFVF_W-1:0] PORT_PF_VF_INFO = '0,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        port_rst,
  input  logic [NUM_PORTS-1:0]        rx_a_tvalid,
  output logic [NUM_PORTS-1:0]        rx_a_tready,
  input  logic [NUM_PORTS-1:0]        rx_a_tlast,
  input  logic [NUM_PORTS*DATA_W-1:0] rx_a_tdata,
  output logic [NUM_PORTS-1:0]        tx_a_tvalid,
  input  logic [NUM_PORTS-1:0]        tx_a_tready,
  output logic [NUM_PORTS-1:0]        tx_a_tlast,
  output logic [NUM_PORTS*DATA_W-1:0] tx_a_tdata,
  input  logic [NUM_PORTS-1:0]        rx_b_tvalid,
  output logic [NUM_PORTS-1:0]        rx_b_tready,
  output logic [NUM_PORTS-1:0]        tx_b_tvalid
);

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_lane
    afu_null_port_lane #(
      .DATA_W  (DATA_W),
      .FEAT_ID (PORT_FEAT_ID[i*12 +: 12]),
      .PF_VF   (PORT_PF_VF_INFO[i*PFVF_W +: PFVF_W]),
      .CNT_W   (CNT_W)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .port_rst    (port_rst[i]),
      .rx_a_tvalid (rx_a_tvalid[i]),
      .rx_a_tready (rx_a_tready[i]),
      .rx_a_tlast  (rx_a_tlast[i]),
      .rx_a_tdata  (rx_a_tdata[i*DATA_W +: DATA_W]),
      .tx_a_tvalid (tx_a_tvalid[i]),
      .tx_a_tready (tx_a_tready[i]),
      .tx_a_tlast  (tx_a_tlast[i]),
      .tx_a_tdata  (tx_a_tdata[i*DATA_W +: DATA_W]),
      .rx_b_tvalid (rx_b_tvalid[i]),
      .rx_b_tready (rx_b_tready[i]),
      .tx_b_tvalid (tx_b_tvalid[i])
    );
  end

endmodule
